// File: rtl/vga_scan_reader.sv
// rtl/vga_scan_reader.sv - VGA raster timing, VRAM read addressing and iteration-count colour map
// Sync/blank are delayed to line up with colour after the VRAM read latency.
module vga_scan_reader #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int READ_LATENCY = 2,
    parameter int DATA_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pixel_enable,
    output logic [9:0]        vga_row_out,
    output logic [9:0]        vga_col_out,
    input  logic [DATA_W-1:0] vram_in,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [9:0] row_q, row_d, col_q, col_d;
    logic [READ_LATENCY-1:0] act_sr_q, act_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       frame_start_q, frame_start_d;

    logic       h_wrap, v_wrap, act_next, act_raw, hs_raw, vs_raw, pix_max;
    logic [7:0] pix8;

    generate
        if (DATA_W >= 8) begin : g_wide
            assign pix8 = vram_in[7:0];
        end else begin : g_narrow
            assign pix8 = {{(8 - DATA_W){1'b0}}, vram_in};
        end
    endgenerate

    assign pix_max = &vram_in;

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        h_wrap        = (h_q == 10'(H_TOTAL - 1));
        v_wrap        = (v_q == 10'(V_TOTAL - 1));
        if (pixel_enable) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end
            frame_start_d = h_wrap && v_wrap;
        end

        // Address registers are loaded from the next counter value so they always
        // describe the counter position currently held.
        act_next = (h_d < 10'(H_ACTIVE)) && (v_d < 10'(V_ACTIVE));
        row_d    = act_next ? v_d : 10'd0;
        col_d    = act_next ? h_d : 10'd0;

        act_raw = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
        hs_raw  = !((h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw  = !((v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC)));

        act_sr_d  = act_sr_q;
        hs_sr_d   = hs_sr_q;
        vs_sr_d   = vs_sr_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (pixel_enable) begin
            act_sr_d[0] = act_raw;
            hs_sr_d[0]  = hs_raw;
            vs_sr_d[0]  = vs_raw;
            for (int i = 1; i < READ_LATENCY; i++) begin
                act_sr_d[i] = act_sr_q[i-1];
                hs_sr_d[i]  = hs_sr_q[i-1];
                vs_sr_d[i]  = vs_sr_q[i-1];
            end
            hsync_d   = hs_sr_q[READ_LATENCY-1];
            vsync_d   = vs_sr_q[READ_LATENCY-1];
            blank_n_d = act_sr_q[READ_LATENCY-1];
            // Max-iteration points are inside the set and drawn black.
            if (act_sr_q[READ_LATENCY-1] && !pix_max) begin
                r_d = {pix8[2:0], 5'b0};
                g_d = {pix8[5:3], 5'b0};
                b_d = {pix8[7:6], 6'b0};
            end else begin
                r_d = 8'd0;
                g_d = 8'd0;
                b_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            row_q         <= 10'd0;
            col_q         <= 10'd0;
            act_sr_q      <= '0;
            hs_sr_q       <= '1;
            vs_sr_q       <= '1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            b_q           <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            row_q         <= row_d;
            col_q         <= col_d;
            act_sr_q      <= act_sr_d;
            hs_sr_q       <= hs_sr_d;
            vs_sr_q       <= vs_sr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_row_out = row_q;
    assign vga_col_out = col_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// tb/tb_vga_scan_reader.sv - randomized self-checking bench for vga_scan_reader
// Uses a shrunken raster so several whole frames fit in a short run.
module tb_vga_scan_reader;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int L = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_enable = 1'b0;
    logic [7:0] vram_in = 8'd0;
    logic [9:0] vga_row_out, vga_col_out;
    logic       vga_hsync, vga_vsync, vga_blank_n, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;

    vga_scan_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .READ_LATENCY(L), .DATA_W(8)
    ) dut (
        .clock(clock), .reset(reset), .pixel_enable(pixel_enable),
        .vga_row_out(vga_row_out), .vga_col_out(vga_col_out), .vram_in(vram_in),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad = 0;
    int n = 0;
    int mode = 0;
    int salt = 0;
    int fs_count;
    logic [19:0] hist [L];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (tick %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [7:0] vram_fn(input int row, input int col);
        logic [31:0] t;
        if (mode == 0) begin
            t = col;
        end else begin
            if (((col + row * 3 + salt) % 11) == 0) return 8'hFF;
            t = col * 7 + row * 13 + salt;
        end
        return t[7:0];
    endfunction

    function automatic logic [23:0] colour(input logic [7:0] d);
        if (d == 8'hFF) return 24'd0;
        return {d[2:0], 5'b0, d[5:3], 5'b0, d[7:6], 6'b0};
    endfunction

    task automatic check_all(input logic en);
        int q, p, h, v;
        logic act, e_hs, e_vs;
        logic [23:0] e_rgb;
        q = n - (L + 1);
        if (q < 0) begin
            act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'd0;
        end else begin
            p = q % FRAME; h = p % HT; v = p / HT;
            act   = (h < HA) && (v < VA);
            e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
            e_rgb = act ? colour(vram_fn(v, h)) : 24'd0;
        end
        check("hsync", 32'(vga_hsync), 32'(e_hs));
        check("vsync", 32'(vga_vsync), 32'(e_vs));
        check("blank_n", 32'(vga_blank_n), 32'(act));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
        p = n % FRAME; h = p % HT; v = p / HT;
        act = (h < HA) && (v < VA);
        check("row", 32'(vga_row_out), act ? 32'(v) : 32'd0);
        check("col", 32'(vga_col_out), act ? 32'(h) : 32'd0);
        check("frame_start", 32'(frame_start), 32'(en && n > 0 && (n % FRAME) == 0));
    endtask

    task automatic tick(input logic en);
        logic [19:0] addr;
        logic was_reset;
        addr = {vga_row_out, vga_col_out};
        was_reset = reset;
        pixel_enable = en;
        @(posedge clock);
        #1;
        if (was_reset) begin
            n = 0;
            for (int i = 0; i < L; i++) hist[i] = 20'd0;
        end else if (en) begin
            n++;
            for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = addr;
            vram_in = vram_fn(int'(hist[L-1][19:10]), int'(hist[L-1][9:0]));
        end
        check_all(en && !was_reset);
    endtask

    initial begin
        logic reached;
        for (int i = 0; i < L; i++) hist[i] = 20'd0;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1);
        reset = 1'b0;

        fs_count = 0;
        for (int i = 0; i < FRAME + 60; i++) begin
            tick(1'b1);
            if (frame_start) fs_count++;
        end
        check("fs_count_free", 32'(fs_count), 32'd1);

        mode = 1;
        salt = int'($urandom_range(0, 1000));
        reset = 1'b1;
        tick(1'b1);
        reset = 1'b0;
        for (int i = 0; i < 2 * FRAME + 100; i++) tick($urandom_range(0, 3) != 0);

        reached = 1'b0;
        for (int i = 0; i < 4 * FRAME && !reached; i++) begin
            tick(i % 2 == 0);
            if ((n % FRAME) == 7 * HT + 41) reached = 1'b1;
        end
        check("reach_mid_frame", 32'(reached), 32'd1);
        reset = 1'b1;
        tick(1'b1);
        reset = 1'b0;

        fs_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(i % 2 == 0);
            if (frame_start) fs_count++;
        end
        check("fs_count_half_rate", 32'(fs_count), 32'd1);
        check("ticks_half_rate", 32'(n), 32'(FRAME));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
